// File: rtl/ldpc_enc.sv
// rtl/ldpc_enc.sv - systematic QC-LDPC encoder, message blocks followed by dual-diagonal parity
// Optional feature macro: LDPC_ENC_FRAME_CNT_EN (adds frame_cnt output counting completed frames)
module ldpc_enc #(
  parameter int D       = 8,
  parameter int R       = 5,
  parameter int C       = 3,
  parameter int SHIFT_W = 4,
  parameter logic [C*(R-C)*SHIFT_W-1:0] SHIFT_TBL = 24'h583210
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [D-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [D-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy
`ifdef LDPC_ENC_FRAME_CNT_EN
  ,
  output logic [15:0]  frame_cnt
`endif
);

  localparam int K    = R - C;
  localparam int MC_W = (K > 1) ? $clog2(K) : 1;
  localparam int PC_W = (C > 1) ? $clog2(C) : 1;

  typedef enum logic {ST_MSG, ST_PAR} state_t;

  state_t          state_q;
  logic [MC_W-1:0] msg_cnt_q;
  logic [PC_W-1:0] par_cnt_q;
  logic [D-1:0]    s_q [C];
  logic [D-1:0]    p_prev_q;
  logic [D-1:0]    out_data_q;
  logic            out_valid_q;
  logic            out_last_q;

  logic            load_free;
  logic            msg_acc;
  logic            par_load;
  logic            par_final;
  logic [D-1:0]    s_d [C];
  logic [D-1:0]    par_d;

  // Cyclic shift of one circulant: y[k] = x[(k+s) mod D]; shift values >= D denote an all-zero block.
  function automatic logic [D-1:0] rot(input logic [D-1:0] x, input logic [SHIFT_W-1:0] sh);
    int shi;
    shi = int'(sh);
    if (shi >= D) return '0;
    return (x >> shi) | (x << (D - shi));
  endfunction

  // Handshake qualifiers; the single output register can be refilled on the cycle it is popped.
  always_comb begin
    load_free = !out_valid_q || out_ready;
    msg_acc   = (state_q == ST_MSG) && in_valid && load_free;
    par_load  = (state_q == ST_PAR) && load_free;
    par_final = (par_cnt_q == PC_W'(C - 1));
  end

  // Every block row folds the incoming message block into its syndrome with its own circulant shift.
  always_comb begin
    for (int i = 0; i < C; i++) begin
      s_d[i] = s_q[i];
      for (int j = 0; j < K; j++) begin
        if (msg_cnt_q == MC_W'(j)) begin
          s_d[i] = s_q[i] ^ rot(in_data, SHIFT_TBL[(i*K+j)*SHIFT_W +: SHIFT_W]);
        end
      end
    end
  end

  // Staircase back-substitution: each parity block is its row syndrome XOR the previous parity block.
  always_comb begin
    par_d = s_q[par_cnt_q] ^ ((par_cnt_q == '0) ? '0 : p_prev_q);
  end

  // Frame sequencer: message pass-through with syndrome accumulation, then C parity loads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_MSG;
      msg_cnt_q   <= '0;
      par_cnt_q   <= '0;
      p_prev_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < C; i++) s_q[i] <= '0;
    end else if (msg_acc) begin
      for (int i = 0; i < C; i++) s_q[i] <= s_d[i];
      out_data_q  <= in_data;
      out_valid_q <= 1'b1;
      out_last_q  <= 1'b0;
      if (msg_cnt_q == MC_W'(K - 1)) begin
        msg_cnt_q <= '0;
        state_q   <= ST_PAR;
      end else begin
        msg_cnt_q <= msg_cnt_q + MC_W'(1);
      end
    end else if (par_load) begin
      out_data_q  <= par_d;
      out_valid_q <= 1'b1;
      out_last_q  <= par_final;
      if (par_final) begin
        par_cnt_q <= '0;
        p_prev_q  <= '0;
        state_q   <= ST_MSG;
        for (int i = 0; i < C; i++) s_q[i] <= '0;
      end else begin
        par_cnt_q <= par_cnt_q + PC_W'(1);
        p_prev_q  <= par_d;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign in_ready  = (state_q == ST_MSG) && load_free;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (msg_cnt_q != '0) || (state_q == ST_PAR) || out_valid_q;

`ifdef LDPC_ENC_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Count frames whose final parity block has been consumed downstream; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt_q <= '0;
    end else if (out_valid_q && out_ready && out_last_q) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_ldpc_enc.sv
// tb/tb_ldpc_enc.sv - self-checking bench for ldpc_enc with a codeword-level reference model
module tb_ldpc_enc;

  localparam int D       = 8;
  localparam int R       = 5;
  localparam int C       = 3;
  localparam int K       = R - C;
  localparam int SHIFT_W = 4;
  localparam logic [23:0] TBL = 24'h583210;

  logic         clk = 1'b0;
  logic         rst;
  logic [D-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [D-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
`ifdef LDPC_ENC_FRAME_CNT_EN
  logic [15:0]  frame_cnt;
`endif

  always #5 clk = ~clk;

  ldpc_enc dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
`ifdef LDPC_ENC_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int frames = 0;
  bit chk_en = 1'b0;

  logic [7:0] exp_q  [$];
  logic       expl_q [$];
  logic [7:0] cap_q  [$];
  int         pop_cyc[$];

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  logic       prev_last  = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference rotation straight from the definition y[k] = x[(k+s) mod D].
  function automatic logic [7:0] mrot(input logic [7:0] x, input int s);
    logic [7:0] y;
    y = '0;
    if (s < D) for (int k = 0; k < D; k++) y[k] = x[(k + s) % D];
    return y;
  endfunction

  function automatic int mshift(input int i, input int j);
    logic [23:0] t;
    t = TBL;
    return int'(t[(i*K+j)*SHIFT_W +: SHIFT_W]);
  endfunction

  // Codeword model: message blocks verbatim, then parity solving Hm*m + Hp*p = 0 row by row.
  task automatic push_model(input logic [7:0] m0, input logic [7:0] m1);
    logic [7:0] m [2];
    logic [7:0] syn;
    logic [7:0] p;
    m[0] = m0;
    m[1] = m1;
    for (int j = 0; j < K; j++) begin
      exp_q.push_back(m[j]);
      expl_q.push_back(1'b0);
    end
    p = '0;
    for (int i = 0; i < C; i++) begin
      syn = '0;
      for (int j = 0; j < K; j++) syn ^= mrot(m[j], mshift(i, j));
      p ^= syn;
      exp_q.push_back(p);
      expl_q.push_back(i == C - 1);
    end
  endtask

  // Compare process: every consumed beat against the model, plus hold-stability under backpressure.
  always @(negedge clk) begin
    logic [7:0] e;
    logic       l;
    if (rst && chk_en) begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          l = expl_q.pop_front();
          check("beat_data", 32'(out_data), 32'(e));
          check("beat_last", 32'(out_last), 32'(l));
        end
        cap_q.push_back(out_data);
        pop_cyc.push_back(cyc);
      end
    end
    if (!rst) frames = 0;
    else if (out_valid && out_ready && out_last) frames++;
    prev_stall = rst && out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
  end

  task automatic send_frame(input logic [7:0] m0, input logic [7:0] m1);
    logic [7:0] m [2];
    bit acc;
    int n;
    m[0] = m0;
    m[1] = m1;
    push_model(m0, m1);
    for (int b = 0; b < K; b++) begin
      in_data  = m[b];
      in_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        n++;
      end
      if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cap(input int base, input logic [7:0] l0, input logic [7:0] l1,
                           input logic [7:0] l2, input logic [7:0] l3, input logic [7:0] l4);
    logic [7:0] lit [5];
    lit = '{l0, l1, l2, l3, l4};
    if (cap_q.size() >= base + 5) begin
      for (int i = 0; i < 5; i++) check($sformatf("lit_beat%0d", base + i), 32'(cap_q[base+i]), 32'(lit[i]));
    end else begin
      check("cap_count", 32'(cap_q.size()), 32'(base + 5));
    end
  endtask

  task automatic clear_cap();
    cap_q.delete();
    pop_cyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    chk_en = 1'b1;

    // Frame {01,00}: one beat per cycle at full throughput.
    clear_cap();
    send_frame(8'h01, 8'h00);
    drain();
    check_cap(0, 8'h01, 8'h00, 8'h01, 8'h41, 8'h41);
    if (pop_cyc.size() == 5) check("frame1_span", 32'(pop_cyc[4] - pop_cyc[0]), 32'd4);
    else check("frame1_pops", 32'(pop_cyc.size()), 32'd5);

    // Frame {00,80}: exercises the null circulant and shift 5.
    clear_cap();
    send_frame(8'h00, 8'h80);
    drain();
    check_cap(0, 8'h00, 8'h80, 8'h40, 8'h50, 8'h54);

    // Back-to-back frames with no bubble; accumulators must clear between them.
    clear_cap();
    send_frame(8'h00, 8'h00);
    send_frame(8'h01, 8'h00);
    drain();
    check_cap(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check_cap(5, 8'h01, 8'h00, 8'h01, 8'h41, 8'h41);
    if (pop_cyc.size() == 10) check("b2b_span", 32'(pop_cyc[9] - pop_cyc[0]), 32'd9);
    else check("b2b_pops", 32'(pop_cyc.size()), 32'd10);

    // Backpressure on parity beat 2 for three cycles.
    clear_cap();
    fork
      send_frame(8'h01, 8'h00);
      begin
        int n;
        n = 0;
        while (cap_q.size() < 3 && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_valid", 32'(out_valid), 32'd1);
          check("bp_data", 32'(out_data), 32'h41);
          check("bp_in_ready", 32'(in_ready), 32'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check_cap(0, 8'h01, 8'h00, 8'h01, 8'h41, 8'h41);

    // Reset after one message beat discards the partial frame.
    chk_en   = 1'b0;
    in_data  = 8'h01;
    in_valid = 1'b1;
    @(negedge clk);
    check("partial_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    expl_q.delete();
    clear_cap();
    chk_en = 1'b1;
    send_frame(8'h00, 8'h80);
    drain();
    check_cap(0, 8'h00, 8'h80, 8'h40, 8'h50, 8'h54);

    // Two further frames checked against the model only.
    send_frame(8'hA5, 8'h3C);
    send_frame(8'hFF, 8'hFF);
    drain();
    check("idle_busy", 32'(busy), 32'd0);
`ifdef LDPC_ENC_FRAME_CNT_EN
    check("frame_cnt_lit", 32'(frame_cnt), 32'd3);
    check("frame_cnt_model", 32'(frame_cnt), 32'(frames[15:0]));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
